// File: rtl/matrix_mult_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | matrix_mult_sequencer_pkg : shared fixed-point/matrix/FSM types   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package matrix_mult_sequencer_pkg;

    localparam int DIM = 4;

    typedef logic signed [15:0] fxp_t;

    // Element [r][c] lands at bits 16*(4r+c) when packed onto a 256-bit bus.
    typedef fxp_t [DIM-1:0][DIM-1:0] mat_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_mult_sequencer_fxp_dot4.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | fxp_dot4 : 4-term signed fixed-point dot product with saturation  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
import matrix_mult_sequencer_pkg::*;

module fxp_dot4 #(
    parameter int FRAC_BITS = 8
) (
    input  logic [63:0] row,
    input  logic [63:0] col,
    output fxp_t        result,
    output logic        sat
);

    localparam logic signed [33:0] MAX_VAL = 34'sd32767;
    localparam logic signed [33:0] MIN_VAL = -34'sd32768;

    logic signed [31:0] prod [4];
    logic signed [33:0] sum;
    logic signed [33:0] shifted;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k] = $signed(row[16*k +: 16]) * $signed(col[16*k +: 16]);
            sum     = sum + {{2{prod[k][31]}}, prod[k]};
        end
        // Arithmetic shift gives floor rounding for negative sums.
        shifted = sum >>> FRAC_BITS;
        sat     = 1'b0;
        result  = shifted[15:0];
        if (shifted > MAX_VAL) begin
            result = 16'sh7FFF;
            sat    = 1'b1;
        end else if (shifted < MIN_VAL) begin
            result = 16'sh8000;
            sat    = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_mult_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | matrix_mult_sequencer : 4x4 fixed-point C=A*B, one element/cycle  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
import matrix_mult_sequencer_pkg::*;

module matrix_mult_sequencer #(
    parameter int FRAC_BITS = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [255:0] matA,
    input  logic [255:0] matB,
    output logic [255:0] res_mat,
    output logic         done,
    output logic         busy,
    output logic         overflow
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    mat_t        a_q;
    mat_t        b_q;
    mat_t        c_q;
    logic        ovf_q;
    logic [63:0] row_vec;
    logic [63:0] col_vec;
    fxp_t        dot;
    logic        dot_sat;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (idx == 4'd15) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands come only from the captured copies so later port changes are invisible.
    always_comb begin
        row_vec = a_q[idx[3:2]];
        col_vec = '0;
        for (int k = 0; k < DIM; k++) begin
            col_vec[16*k +: 16] = b_q[k][idx[1:0]];
        end
    end

    fxp_dot4 #(
        .FRAC_BITS (FRAC_BITS)
    ) u_dot (
        .row    (row_vec),
        .col    (col_vec),
        .result (dot),
        .sat    (dot_sat)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx   <= 4'd0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= matA;
                        b_q   <= matB;
                        idx   <= 4'd0;
                        ovf_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    c_q[idx[3:2]][idx[1:0]] <= dot;
                    if (dot_sat) begin
                        ovf_q <= 1'b1;
                    end
                    idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign res_mat  = c_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/matrix_mult_sequencer.md
MATRIX_MULT_SEQUENCER -- requirements
Module: matrix_mult_sequencer

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 8, meaning the number of fractional bits of the signed 16-bit fixed-point format (Q7.8 at default).
REQ-002 SHALL have port Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to multiply; sampled only in IDLE.
REQ-005 SHALL have port matA  input  256  left operand, 16 signed 16-bit elements.
REQ-006 SHALL have port matB  input  256  right operand, same layout as matA.
REQ-007 SHALL have port res_mat  output  256  product matrix C = A*B, same layout as matA.
REQ-008 SHALL have port done  output  1  single-cycle pulse when res_mat is complete.
REQ-009 SHALL have port busy  output  1  high from operand capture until done, inclusive.
REQ-010 SHALL have port overflow  output  1  sticky flag; high if any element of the current result saturated.

Function
REQ-011 Element (r,c), r,c in 0..3, SHALL occupy bits [16*(4r+c)+15 : 16*(4r+c)] of every matrix port.
REQ-012 FSM states SHALL be IDLE, COMPUTE, DONE; the reset state is IDLE.
REQ-013 In IDLE with start=1 at edge T: matA/matB SHALL be copied into internal operand registers, the element index cleared to 0, overflow cleared, and the state set to COMPUTE.
REQ-014 In IDLE with start=0, all registers SHALL hold.
REQ-015 In COMPUTE, each cycle SHALL compute one element with index i (r=i[3:2], c=i[1:0]) as the dot product of row r of the captured A and column c of the captured B, and SHALL write it into res_mat at the edge ending that cycle.
REQ-016 The index SHALL increment 0..15; after writing i=15 the state SHALL go to DONE, so compute spans edges T+1..T+16.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle (cycle after edge T+16), and the state SHALL then return to IDLE unconditionally.
REQ-018 start SHALL be ignored in COMPUTE and DONE; input changes to matA/matB after edge T SHALL NOT affect the result.
REQ-019 With start held high continuously, a new operation SHALL be captured on the first IDLE cycle following DONE (period 18 cycles).
REQ-020 Arithmetic: the four 32-bit signed products SHALL be summed at 34-bit full precision, then arithmetically shifted right by FRAC_BITS (floor), then saturated to [-32768, 32767].
REQ-021 When saturation occurs for any element, overflow SHALL be set at that element's write edge and held until the next capture.
REQ-022 res_mat SHALL hold its last value from DONE until it is overwritten element-wise in the next COMPUTE; partially updated values during COMPUTE are not valid.
REQ-023 busy SHALL be 1 in COMPUTE and DONE and 0 in IDLE.

Reset
REQ-024 Reset=1 SHALL asynchronously force: state IDLE, index 0, operand registers 0, res_mat 0, done 0, busy 0, overflow 0.
REQ-025 Reset asserted mid-COMPUTE SHALL abort the operation without a done pulse; the first start after Reset deasserts SHALL begin a fresh operation.

Structure
REQ-026 A shared package SHALL hold the fixed-point element typedef (signed 16-bit), a 4x4 matrix typedef, the FSM state enum, and the matrix dimension constant 4.
REQ-027 One combinational sub-module fxp_dot4 (two 64-bit row/column vectors in, 16-bit saturated result plus saturate flag out, FRAC_BITS parameter) SHALL be instantiated exactly once and time-shared over the 16 elements.
REQ-028 The row/column selection for fxp_dot4 SHALL be muxed from the operand registers by the index, never from the matA/matB ports directly.

Verification
REQ-029 Identity: A = diag(0x0100), B = elements 0x0001..0x0010, start pulse at edge T -> done only in the cycle after T+16, res_mat == B, overflow=0.
REQ-030 Sign: A = diag(0xFF00), B = all 0x0200 -> every element 0xFE00 (-2.0); A = all 0x0080, B = all 0x0080 -> every element 0x0100 (4 x 0.25 = 1.0).
REQ-031 Saturation: A = B = all 0x7FFF -> every element 0x7FFF, overflow=1; A = all 0x8000, B = all 0x7FFF -> every element 0x8000, overflow=1.
REQ-032 Busy protection: start pulsed with new matA/matB at T+5 -> ignored, result matches the operands captured at T, one done pulse only.
REQ-033 Reset mid-operation: Reset asserted at T+8 for one cycle -> res_mat=0, busy=0, done never asserted; the next start produces the correct result 17 cycles later.
REQ-034 Back-to-back: start held high -> done pulses exactly 18 cycles apart, and the second result reflects operands present at the second capture edge.
